// File: rtl/acq_sequencer.sv
// acq_sequencer: capture-side sequencer for the double-banked sample RAM.
// Fills pre-trigger history, waits for a level crossing (or an auto-mode
// timeout), fills post-trigger samples, then hands the finished bank to the
// display only when the display signals a frame boundary.
// Build option: define TRIG_SLOPE_SEL_EN to add the trig_falling input, which
// selects a falling-edge trigger for the capture it is latched into.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for run level or a single pulse
// S_PRE_FILL | writing the pre-trigger history (pre samples)
// S_ARMED    | writing samples while looking for the trigger condition
// S_POST_FILL| writing the samples that follow the trigger
// S_HOLD     | capture complete, waiting for frame_start to swap banks
module acq_sequencer #(
  parameter int DW           = 12,
  parameter int AW           = 8,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          single,
  input  logic          mode_auto,
  input  logic          smp_valid,
  input  logic [DW-1:0] smp_data,
  input  logic [DW-1:0] trig_level,
`ifdef TRIG_SLOPE_SEL_EN
  input  logic          trig_falling,
`endif
  input  logic [AW-1:0] pretrig,
  input  logic          frame_start,
  output logic          wr_en,
  output logic [AW:0]   wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          disp_bank,
  output logic [AW-1:0] disp_base,
  output logic          capture_done,
  output logic          triggered,
  output logic          busy
);

  localparam int            CW      = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(AUTO_TIMEOUT - 1);
  localparam logic [CW-1:0] TO_SAT  = CW'(AUTO_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] IDX_MAX = '1;
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_FILL, S_ARMED, S_POST_FILL, S_HOLD
  } state_t;

  state_t        state_q, state_nxt;
  logic          wbank;
  logic [AW-1:0] idx;
  logic [AW-1:0] pre_q;
  logic [AW-1:0] fill_rem;
  logic [AW-1:0] post_rem;
  logic [AW-1:0] taddr;
  logic [CW-1:0] armed_cnt;
  logic [DW-1:0] prev_q;
  logic          prev_valid;
  logic          single_mode;
  logic          trig_flag;

  logic          abort, accept, fire, real_trig, timeout, enter_pre, swap;
  logic          edge_hit;
  logic [AW-1:0] post_len;

  assign busy     = (state_q != S_IDLE);
  // Samples after the trigger fill the rest of the bank: DEPTH-1-pre.
  assign post_len = IDX_MAX - pre_q;

`ifdef TRIG_SLOPE_SEL_EN
  logic falling_q;

  assign edge_hit = falling_q ? (prev_q > trig_level && smp_data <= trig_level)
                              : (prev_q < trig_level && smp_data >= trig_level);

  // Slope choice is frozen for the whole capture, like pretrig.
  always_ff @(posedge clk) begin
    if (!rst)           falling_q <= 1'b0;
    else if (enter_pre) falling_q <= trig_falling;
  end
`else
  assign edge_hit = (prev_q < trig_level) && (smp_data >= trig_level);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state decode and per-cycle control strobes for the datapath.
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    fire      = 1'b0;
    real_trig = 1'b0;
    timeout   = 1'b0;
    enter_pre = 1'b0;
    swap      = 1'b0;
    abort     = busy && !single_mode && !run;
    case (state_q)
      S_IDLE: begin
        if (run || single) begin
          state_nxt = S_PRE_FILL;
          enter_pre = 1'b1;
        end
      end
      S_PRE_FILL: begin
        if (abort)                state_nxt = S_IDLE;
        else if (fill_rem == '0)  state_nxt = S_ARMED;
        else if (smp_valid) begin
          accept = 1'b1;
          if (fill_rem == IDX_ONE) state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (abort) state_nxt = S_IDLE;
        else if (smp_valid) begin
          accept    = 1'b1;
          real_trig = prev_valid && edge_hit;
          timeout   = mode_auto && (armed_cnt >= TO_LAST);
          fire      = real_trig || timeout;
          if (fire) state_nxt = (post_len == '0) ? S_HOLD : S_POST_FILL;
        end
      end
      S_POST_FILL: begin
        if (abort) state_nxt = S_IDLE;
        else if (smp_valid) begin
          accept = 1'b1;
          if (post_rem == IDX_ONE) state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort) state_nxt = S_IDLE;
        else if (frame_start) begin
          swap = 1'b1;
          if (run && !single_mode) begin
            state_nxt = S_PRE_FILL;
            enter_pre = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture datapath: RAM write port, fill counters, trigger bookkeeping, bank swap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      disp_bank    <= 1'b0;
      disp_base    <= '0;
      capture_done <= 1'b0;
      triggered    <= 1'b0;
      wbank        <= 1'b1;
      idx          <= '0;
      pre_q        <= '0;
      fill_rem     <= '0;
      post_rem     <= '0;
      taddr        <= '0;
      armed_cnt    <= '0;
      prev_q       <= '0;
      prev_valid   <= 1'b0;
      single_mode  <= 1'b0;
      trig_flag    <= 1'b0;
    end else begin
      wr_en        <= accept;
      capture_done <= swap;
      if (accept) begin
        wr_addr    <= {wbank, idx};
        wr_data    <= smp_data;
        idx        <= idx + IDX_ONE;
        prev_q     <= smp_data;
        prev_valid <= 1'b1;
      end
      // pretrig is AW bits wide, so it can never exceed DEPTH-1.
      if (enter_pre) begin
        pre_q       <= pretrig;
        fill_rem    <= pretrig;
        single_mode <= !run;
        prev_valid  <= 1'b0;
      end
      if (accept && state_q == S_PRE_FILL) fill_rem <= fill_rem - IDX_ONE;
      if (state_q != S_ARMED)                       armed_cnt <= '0;
      else if (accept && armed_cnt != TO_SAT)       armed_cnt <= armed_cnt + CNT_ONE;
      if (fire) begin
        taddr     <= idx;
        trig_flag <= real_trig;
        post_rem  <= post_len;
      end
      if (accept && state_q == S_POST_FILL) post_rem <= post_rem - IDX_ONE;
      if (swap) begin
        disp_bank <= wbank;
        disp_base <= taddr - pre_q;
        triggered <= trig_flag;
        wbank     <= ~wbank;
      end
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
`timescale 1ns/1ps
// Randomized + directed scoreboard bench for acq_sequencer.
module tb_acq_sequencer;

  localparam int DW    = 12;
  localparam int AW    = 8;
  localparam int TO    = 50;
  localparam int DEPTH = 256;

  typedef logic [11:0] smp_q_t[$];
  typedef struct { logic [8:0] addr; logic [11:0] data; } wr_t;
  typedef struct { logic bank; logic [7:0] base; logic trig; } hand_t;

  logic          clk = 1'b0;
  logic          rst, run, single, mode_auto, smp_valid, frame_start;
  logic [DW-1:0] smp_data, trig_level;
  logic [AW-1:0] pretrig;
  logic          wr_en, disp_bank, capture_done, triggered, busy;
  logic [AW:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] disp_base;

  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  bit    all_done = 0;
  wr_t   exp_wr[$];
  hand_t exp_hand[$];

  // behavioural model state: running write index and bank bookkeeping
  int         m_idx;
  logic       m_wbank, m_dbank, m_trig;
  logic [7:0] m_dbase;

  always #5 clk = ~clk;

  acq_sequencer #(.DW(DW), .AW(AW), .AUTO_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .single(single), .mode_auto(mode_auto),
    .smp_valid(smp_valid), .smp_data(smp_data), .trig_level(trig_level),
    .pretrig(pretrig), .frame_start(frame_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .disp_bank(disp_bank),
    .disp_base(disp_base), .capture_done(capture_done),
    .triggered(triggered), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic smp_q_t ramp(input int start, input int step, input int len);
    smp_q_t q;
    for (int i = 0; i < len; i++) q.push_back(12'((start + i * step) % 4096));
    return q;
  endfunction

  function automatic smp_q_t konst(input int v, input int len);
    smp_q_t q;
    for (int i = 0; i < len; i++) q.push_back(12'(v));
    return q;
  endfunction

  function automatic smp_q_t rnd(input int len);
    smp_q_t q;
    for (int i = 0; i < len; i++) q.push_back(12'($urandom_range(0, 4095)));
    return q;
  endfunction

  // Position (within the capture's sample stream) of the sample that ends the
  // armed wait, or -1. Samples 0..pre-1 are history; from sample pre onward a
  // rising crossing against the previous sample of this capture triggers, and
  // in auto mode the TO-th armed sample forces one.
  function automatic int find_trig(input smp_q_t s, input int pre, input int lvl,
                                   input bit au, output bit rt);
    rt = 0;
    for (int j = pre; j < s.size(); j++) begin
      if (j >= 1 && int'(s[j-1]) < lvl && int'(s[j]) >= lvl) begin
        rt = 1;
        return j;
      end
      if (au && (j - pre + 1) == TO) return j;
    end
    return -1;
  endfunction

  task automatic do_reset;
    rst = 0; run = 0; single = 0; smp_valid = 0; frame_start = 0;
    tick(2);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_disp_bank", int'(disp_bank), 0);
    chk("rst_disp_base", int'(disp_base), 0);
    chk("rst_capture_done", int'(capture_done), 0);
    chk("rst_triggered", int'(triggered), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending_writes", exp_wr.size(), 0);
    m_idx = 0; m_wbank = 1; m_dbank = 0; m_dbase = 0; m_trig = 0;
    rst = 1;
    tick(1);
  endtask

  task automatic do_capture(input string tag, input bit sgl, input int pre,
                            input int lvl, input bit au, input smp_q_t s,
                            input bit coincide, input bit end_rst);
    int j, n, nd, idx0, d0;
    bit rt;
    logic [7:0] base;
    j = find_trig(s, pre, lvl, au, rt);
    n = (j < 0) ? s.size() : j + DEPTH - pre;
    if (j >= 0) while (s.size() < n + 2) s.push_back(12'($urandom_range(0, 4095)));
    nd = (j < 0) ? s.size() : n + 2;
    idx0 = m_idx;
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = {m_wbank, 8'((idx0 + i) % DEPTH)};
      w.data = s[i];
      exp_wr.push_back(w);
    end
    m_idx = (idx0 + n) % DEPTH;
    d0 = done_cnt;

    pretrig = 8'(pre); trig_level = 12'(lvl); mode_auto = au;
    if (sgl) single = 1; else run = 1;
    tick(1);
    single = 0;
    tick(2);
    for (int i = 0; i < nd; i++) begin
      smp_valid = 1;
      smp_data = s[i];
      frame_start = coincide && (j >= 0) && (i == n - 1);
      tick(1);
      smp_valid = 0;
      frame_start = 0;
      tick(3);
    end

    if (end_rst) begin
      chk({tag, "_busy_before_rst"}, int'(busy), 1);
      do_reset();
      return;
    end

    if (j < 0) begin
      chk({tag, "_busy_untriggered"}, int'(busy), 1);
      frame_start = 1; tick(1); frame_start = 0; tick(3);
      chk({tag, "_no_handoff"}, done_cnt - d0, 0);
      run = 0; tick(2);
      chk({tag, "_busy_after_abort"}, int'(busy), 0);
      chk({tag, "_disp_bank_kept"}, int'(disp_bank), int'(m_dbank));
      chk({tag, "_disp_base_kept"}, int'(disp_base), int'(m_dbase));
      chk({tag, "_triggered_kept"}, int'(triggered), int'(m_trig));
      return;
    end

    chk({tag, "_busy_hold"}, int'(busy), 1);
    chk({tag, "_no_early_handoff"}, done_cnt - d0, 0);
    base = 8'((idx0 + j - pre) % DEPTH);
    exp_hand.push_back('{bank: m_wbank, base: base, trig: rt});
    m_dbank = m_wbank; m_dbase = base; m_trig = rt; m_wbank = ~m_wbank;

    frame_start = 1; tick(1); frame_start = 0;
    if (!sgl) run = 0;
    chk({tag, "_busy_after_swap"}, int'(busy), sgl ? 0 : 1);
    tick(1);
    chk({tag, "_busy_settled"}, int'(busy), 0);
    for (int k = 0; k < 4 && done_cnt == d0; k++) tick(1);
    chk({tag, "_handoff_count"}, done_cnt - d0, 1);
    chk({tag, "_disp_bank"}, int'(disp_bank), int'(m_dbank));
    chk({tag, "_disp_base"}, int'(disp_base), int'(m_dbase));
    chk({tag, "_triggered"}, int'(triggered), int'(m_trig));

    if (sgl) begin
      frame_start = 1; tick(1); frame_start = 0; tick(3);
      for (int k = 0; k < 2; k++) begin
        smp_valid = 1; smp_data = 12'($urandom_range(0, 4095));
        tick(1); smp_valid = 0; tick(3);
      end
      chk({tag, "_single_no_repeat"}, done_cnt - d0, 1);
      chk({tag, "_single_idle"}, int'(busy), 0);
    end
  endtask

  task automatic run_tests;
    do_reset();
    do_capture("norm_const", 0, 8, 2048, 0, konst(100, 300), 0, 0);
    do_capture("ramp_run", 0, 16, 2048, 0, ramp(0, 16, 380), 0, 0);
    do_capture("auto_const", 0, 16, 2048, 1, konst(100, 310), 0, 0);
    do_capture("single", 1, 32, 1000, 0, ramp(0, 16, 300), 0, 0);
    do_capture("coincide", 0, 40, 3000, 0, ramp(0, 16, 420), 1, 0);
    do_capture("pre255", 0, 255, 2048, 0, ramp(0, 16, 390), 0, 0);
    do_capture("pre0", 0, 0, 2048, 0, ramp(0, 16, 390), 0, 0);
    do_capture("abort_armed", 0, 4, 4000, 0, konst(100, 40), 0, 0);
    for (int r = 0; r < 6; r++) begin
      int pre, lvl;
      bit au, sgl, co;
      pre = $urandom_range(0, 255);
      lvl = $urandom_range(512, 3583);
      sgl = 1'($urandom_range(0, 1));
      au  = sgl ? 1'b1 : 1'($urandom_range(0, 1));
      co  = ($urandom_range(0, 3) == 0);
      do_capture("rand", sgl, pre, lvl, au, rnd(pre + TO + DEPTH + 4), co, 0);
    end
    do_capture("rst_mid", 0, 8, 4000, 0, ramp(0, 5, 20), 0, 1);
    do_capture("post_rst", 0, 0, 100, 0, ramp(0, 16, 270), 0, 0);
  endtask

  initial begin
    rst = 0; run = 0; single = 0; mode_auto = 0; smp_valid = 0;
    smp_data = '0; trig_level = '0; pretrig = '0; frame_start = 0;
    fork
      begin
        while (!all_done) begin
          @(negedge clk);
          if (rst === 1'b1) begin
            if (wr_en) begin
              if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected got addr=%0h data=%0h expected no write",
                         wr_addr, wr_data);
              end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("wr_addr", int'(wr_addr), int'(w.addr));
                chk("wr_data", int'(wr_data), int'(w.data));
              end
            end
            if (capture_done) begin
              done_cnt++;
              if (exp_hand.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handoff_unexpected got bank=%0d base=%0d expected none",
                         disp_bank, disp_base);
              end else begin
                hand_t h;
                h = exp_hand.pop_front();
                chk("hand_bank", int'(disp_bank), int'(h.bank));
                chk("hand_base", int'(disp_base), int'(h.base));
                chk("hand_triggered", int'(triggered), int'(h.trig));
              end
            end
          end
        end
      end
      begin
        run_tests();
        tick(4);
        all_done = 1;
      end
    join
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_hand_drained", exp_hand.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
